// File: rtl/wait_time_calc_if.sv
// wait_time_calc_if: request/result bundle between the queue counters and the wait-time estimator.
interface wait_time_calc_if #(
  parameter int P_W = 3,
  parameter int T_W = 2,
  parameter int W_W = 5
);
  logic start;
  logic [P_W-1:0] pcount;
  logic [T_W-1:0] tcount;
  logic busy;
  logic valid;
  logic [W_W-1:0] wtime;
  logic ovf;
  modport master (output start, pcount, tcount, input busy, valid, wtime, ovf);
  modport slave (input start, pcount, tcount, output busy, valid, wtime, ovf);
endinterface

// File: rtl/wait_time_calc.sv
// wait_time_calc: wtime = SVC_TIME*(pcount+tcount-1)/tcount via a restoring shift-subtract divider.
// WTIME_SAT_EN selects saturation with ovf; otherwise the quotient wraps to W_W bits.
module wait_time_calc #(
  parameter int P_W      = 3,
  parameter int T_W      = 2,
  parameter int SVC_TIME = 3,
  parameter int W_W      = 5
) (
  input logic clk,
  input logic rst,
  wait_time_calc_if.slave bus
);
  localparam int NUM_W = P_W + T_W + 4;
  localparam int CNT_W = $clog2(NUM_W);
  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [P_W-1:0] p_q, p_d;
  logic [T_W-1:0] t_q, t_d;
  logic [NUM_W-1:0] num_q, num_d, prod;
  logic [T_W-1:0] rem_q, rem_d, diff;
  logic [T_W:0] shl;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W_W-1:0] wtime_q, wtime_d;
  logic ovf_q, ovf_d, valid_q, valid_d, zero, ge;
  assign prod = NUM_W'(SVC_TIME) * (NUM_W'(p_q) + NUM_W'(t_q) - NUM_W'(1));
  assign zero = (p_q == '0) || (t_q == '0);
  // remainder stays below the divisor, so T_W bits suffice once the next numerator bit is shifted in
  assign shl = {rem_q, num_q[NUM_W-1]};
  assign ge = shl >= {1'b0, t_q};
  assign diff = T_W'(shl - {1'b0, t_q});
  always_comb begin
    state_d = state_q;
    p_d = p_q;
    t_d = t_q;
    num_d = num_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    wtime_d = wtime_q;
    ovf_d = ovf_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        p_d = bus.pcount;
        t_d = bus.tcount;
        state_d = LOAD;
      end
      LOAD: begin
        rem_d = '0;
        cnt_d = CNT_W'(NUM_W - 1);
        num_d = zero ? '0 : prod;
        state_d = zero ? DONE : DIV;
      end
      DIV: begin
        num_d = {num_q[NUM_W-2:0], ge};
        rem_d = ge ? diff : shl[T_W-1:0];
        cnt_d = cnt_q - CNT_W'(1);
        state_d = (cnt_q == '0) ? DONE : DIV;
      end
      DONE: begin
        valid_d = 1'b1;
        state_d = IDLE;
`ifdef WTIME_SAT_EN
        ovf_d = num_q > NUM_W'((2 ** W_W) - 1);
        wtime_d = ovf_d ? '1 : num_q[W_W-1:0];
`else
        ovf_d = 1'b0;
        wtime_d = num_q[W_W-1:0];
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q <= '0;
      t_q <= '0;
      num_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      wtime_q <= '0;
      ovf_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q <= p_d;
      t_q <= t_d;
      num_q <= num_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      wtime_q <= wtime_d;
      ovf_q <= ovf_d;
      valid_q <= valid_d;
    end
  end
  assign bus.busy = (state_q == LOAD) || (state_q == DIV);
  assign bus.valid = valid_q;
  assign bus.wtime = wtime_q;
  assign bus.ovf = ovf_q;
endmodule
